// File: rtl/vec_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vec_pkg;

  localparam int LANES      = 5;
  localparam int DW         = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef logic [2:0] idx_t;

endpackage

// File: rtl/vec_lane_buf.sv
// LANES x DW lane register array: parallel load, single indexed write port,
// and all lanes presented in parallel. Cleared asynchronously.
module vec_lane_buf
  import vec_pkg::idx_t;
#(
  parameter int LANES = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [LANES*DW-1:0] load_d,
  input  logic                we,
  input  idx_t                idx,
  input  logic [DW-1:0]       d,
  output logic [LANES*DW-1:0] q
);

  logic [DW-1:0] regs [LANES];

  // NOTE: this array is deliberately reset -- an aborted load must not leave
  // partial lane data visible on the outputs after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) regs[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < LANES; i++) regs[i] <= load_d[i*DW +: DW];
    end else if (we && (int'(idx) < LANES)) begin
      regs[idx] <= d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign q[g*DW +: DW] = regs[g];
  end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: one data-memory word per cycle while stalling
// the PC, then a single vector register file write pulse for loads.
module vec_mem_seq
  import vec_pkg::state_t;
  import vec_pkg::idx_t;
  import vec_pkg::IDLE;
  import vec_pkg::XFER;
  import vec_pkg::FINISH;
  import vec_pkg::WORD_BYTES;
#(
  parameter int LANES = 5,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_store,
  input  logic [AW-1:0] base_addr,
  input  logic [DW-1:0] st_lane_0,
  input  logic [DW-1:0] st_lane_1,
  input  logic [DW-1:0] st_lane_2,
  input  logic [DW-1:0] st_lane_3,
  input  logic [DW-1:0] st_lane_4,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [DW-1:0] ld_lane_0,
  output logic [DW-1:0] ld_lane_1,
  output logic [DW-1:0] ld_lane_2,
  output logic [DW-1:0] ld_lane_3,
  output logic [DW-1:0] ld_lane_4,
  output logic          vec_we,
  output logic          stall,
  output logic          busy,
  output logic          done
);

  state_t              state;
  idx_t                idx;
  logic                is_store_r;
  logic [AW-1:0]       base_r;
  logic [LANES*DW-1:0] snap_q;
  logic [LANES*DW-1:0] buf_q;
  logic                accept;
  logic                in_xfer;

  assign accept  = (state == IDLE) && start;
  assign in_xfer = (state == XFER);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      is_store_r <= 1'b0;
      base_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= XFER;
            idx        <= '0;
            is_store_r <= is_store;
            base_r     <= {base_addr[AW-1:2], 2'b00};
          end
        end
        XFER: begin
          if (idx == idx_t'(LANES - 1)) state <= FINISH;
          else                          idx   <= idx + idx_t'(1);
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store lanes are frozen at acceptance so the decoder may move on.
  vec_lane_buf #(.LANES(LANES), .DW(DW)) u_snap (
    .clk    (clk),
    .rst_n  (reset),
    .load   (accept),
    .load_d ({st_lane_4, st_lane_3, st_lane_2, st_lane_1, st_lane_0}),
    .we     (1'b0),
    .idx    (idx),
    .d      ('0),
    .q      (snap_q)
  );

  vec_lane_buf #(.LANES(LANES), .DW(DW)) u_ldbuf (
    .clk    (clk),
    .rst_n  (reset),
    .load   (1'b0),
    .load_d ('0),
    .we     (in_xfer && !is_store_r),
    .idx    (idx),
    .d      (mem_rdata),
    .q      (buf_q)
  );

  // NOTE: every output gets a default first so no path through this block
  // can infer a latch.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (in_xfer) begin
      // Address arithmetic is modulo 2^AW, so a vector may wrap past the top.
      mem_addr = base_r + AW'(idx) * AW'(WORD_BYTES);
      if (is_store_r) begin
        mem_we    = 1'b1;
        mem_wdata = snap_q[int'(idx)*DW +: DW];
      end
    end
  end

  assign done   = (state == FINISH);
  assign vec_we = (state == FINISH) && !is_store_r;
  assign busy   = (state != IDLE);
  assign stall  = accept || in_xfer;

  assign ld_lane_0 = buf_q[0*DW +: DW];
  assign ld_lane_1 = buf_q[1*DW +: DW];
  assign ld_lane_2 = buf_q[2*DW +: DW];
  assign ld_lane_3 = buf_q[3*DW +: DW];
  assign ld_lane_4 = buf_q[4*DW +: DW];

endmodule
